// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder
//   Receive side of the RGB PWM link. Each of the three PWM lines (R, G, B)
//   is synchronised to clk, its high time is counted over a window one PWM
//   period long (2**WIDTH clk), and the 24-bit colour word {R,G,B} is rebuilt.
//   color_valid pulses for one clk each time color_hex is refreshed.
//   Optional build macro RGB_PWM_DEGLITCH_EN: when defined, each synchronised
//   line passes through a 3-tap majority filter (2 clk extra latency) so that
//   isolated 1-clk pulses and dropouts are rejected.
module rgb_pwm_decoder #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [2:0]  pwm_in,
    output logic [23:0] color_hex,
    output logic        color_valid,
    output logic [2:0]  pwm_active
);

    // Last count of a window and the full-scale count that must saturate.
    localparam logic [WIDTH-1:0] WIN_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   FULL_CNT = {1'b1, {WIDTH{1'b0}}};

    logic [2:0]       sync1_reg;
    logic [2:0]       sync2_reg;
    logic [2:0]       s_filt;
    logic [2:0]       s_d_reg;
    logic [2:0]       edge_now;
    logic [2:0]       edge_seen;
    logic [WIDTH-1:0] win_cnt_reg;
    logic             win_close;
    logic [7:0]       chan_byte [3];

    // Two-flop synchroniser on every PWM line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pwm_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef RGB_PWM_DEGLITCH_EN
    logic [2:0] tap0_reg;
    logic [2:0] tap1_reg;
    logic [2:0] tap2_reg;

    // Three-sample history of each synchronised line for the majority vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap0_reg <= '0;
            tap1_reg <= '0;
            tap2_reg <= '0;
        end else begin
            tap0_reg <= sync2_reg;
            tap1_reg <= tap0_reg;
            tap2_reg <= tap1_reg;
        end
    end

    // A level only counts once two of the last three samples agree.
    assign s_filt = (tap0_reg & tap1_reg) | (tap1_reg & tap2_reg) | (tap0_reg & tap2_reg);
`else
    assign s_filt = sync2_reg;
`endif

    // Previous filtered sample, used only for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_reg <= '0;
        end else begin
            s_d_reg <= s_filt;
        end
    end

    assign edge_now  = s_filt ^ s_d_reg;
    assign win_close = enable && (win_cnt_reg == WIN_LAST);

    // Free-running window counter; parked at 0 while disabled so that
    // enabling always starts a fresh, full-length window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_reg <= '0;
        end else if (enable) begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
        end else begin
            win_cnt_reg <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [WIDTH:0]   hi_cnt_reg;
            logic             edge_seen_reg;
            logic [WIDTH:0]   total;
            logic [WIDTH-1:0] sat_val;

            // The sample taken on the closing edge is included in the total.
            assign total   = hi_cnt_reg + {{WIDTH{1'b0}}, s_filt[gi]};
            // A line high for the whole window reads as full scale.
            assign sat_val = (total == FULL_CNT) ? {WIDTH{1'b1}} : total[WIDTH-1:0];
            // Left-justify so that the result is always an 8-bit colour byte.
            assign chan_byte[gi] = 8'(sat_val) << (8 - WIDTH);
            assign edge_seen[gi] = edge_seen_reg;

            // High-time counter: cleared at window close and while disabled.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hi_cnt_reg <= '0;
                end else if (!enable || win_close) begin
                    hi_cnt_reg <= '0;
                end else if (s_filt[gi]) begin
                    hi_cnt_reg <= hi_cnt_reg + 1'b1;
                end
            end

            // Sticky edge flag for the current window.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    edge_seen_reg <= 1'b0;
                end else if (!enable || win_close) begin
                    edge_seen_reg <= 1'b0;
                end else if (edge_now[gi]) begin
                    edge_seen_reg <= 1'b1;
                end
            end
        end
    endgenerate

    // Publish the window result; outputs hold between windows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_hex   <= '0;
            color_valid <= 1'b0;
            pwm_active  <= '0;
        end else if (win_close) begin
            color_hex   <= {chan_byte[0], chan_byte[1], chan_byte[2]};
            color_valid <= 1'b1;
            pwm_active  <= edge_seen | edge_now;
        end else begin
            color_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Directed testbench for rgb_pwm_decoder: an 8-bit instance for the main
// scenarios and a 4-bit instance for the reduced-resolution and spike cases.
module tb_rgb_pwm_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        enable4;
    logic [2:0]  pwm8;
    logic [2:0]  pwm4;
    logic [23:0] hex8;
    logic [23:0] hex4;
    logic        cv8;
    logic        cv4;
    logic [2:0]  act8;
    logic [2:0]  act4;

    int unsigned src_cnt = 0;
    int          cyc = 0;
    logic [8:0]  duty [3];
    logic [7:0]  phase;
    logic [7:0]  ph8;
    logic [3:0]  nib;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        src_cnt <= src_cnt + 1;
        cyc     <= cyc + 1;
    end

    // Periodic PWM sources: 256-clk period for the 8-bit instance,
    // 16-clk period for the 4-bit instance (B carries one 1-clk spike).
    assign ph8 = 8'(src_cnt) + phase;
    assign nib = src_cnt[3:0];

    always_comb begin
        pwm8 = '0;
        for (int i = 0; i < 3; i++) begin
            pwm8[i] = ({1'b0, ph8} < duty[i]);
        end
    end

    always_comb begin
        pwm4    = '0;
        pwm4[0] = (nib < 4'd4);
        pwm4[1] = (nib < 4'd12);
        pwm4[2] = (nib == 4'd9);
    end

    rgb_pwm_decoder #(.WIDTH(8)) u8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pwm_in      (pwm8),
        .color_hex   (hex8),
        .color_valid (cv8),
        .pwm_active  (act8)
    );

    rgb_pwm_decoder #(.WIDTH(4)) u4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable4),
        .pwm_in      (pwm4),
        .color_hex   (hex4),
        .color_valid (cv4),
        .pwm_active  (act4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
            $display("ok   %s: %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for color_valid on the chosen instance; n = clocks waited (0 = timeout).
    task automatic wait_pulse(input bit sel, input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if ((sel ? cv4 : cv8) === 1'b1) begin
                n = k + 1;
                break;
            end
        end
        check("pulse_seen", 32'(n != 0), 32'd1);
    endtask

    logic [23:0] exp4;
    logic [2:0]  exp_act4;

    initial begin
        int n;
        int t;
        int cnt;

        reset_n = 1'b0;
        enable  = 1'b0;
        enable4 = 1'b0;
        duty[0] = 9'd64;
        duty[1] = 9'd128;
        duty[2] = 9'd192;
        phase   = 8'd0;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_hex", 32'(hex8), 32'h0);
        check("rst_valid", 32'(cv8), 32'h0);
        check("rst_active", 32'(act8), 32'h0);
        check("rst_hex4", 32'(hex4), 32'h0);

        // Test 1: 64/128/192 -> 0x4080C0, pulses 256 apart
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b1;
        wait_pulse(1'b0, 300, n);
        check("t1_first_lat", 32'(n), 32'd256);
        check("t1_hex0", 32'(hex8), 32'h4080C0);
        t = cyc;
        @(posedge clk);
        #1;
        check("t1_pulse_width", 32'(cv8), 32'h0);
        for (int p = 0; p < 2; p++) begin
            wait_pulse(1'b0, 300, n);
            check("t1_hex", 32'(hex8), 32'h4080C0);
            check("t1_spacing", 32'(cyc - t), 32'd256);
            t = cyc;
        end
        check("t1_active", 32'(act8), 32'h7);

        // Test 3: phase offset 37 -> same value from second window on
        phase = 8'd37;
        wait_pulse(1'b0, 300, n);
        wait_pulse(1'b0, 300, n);
        check("t3_hex_w2", 32'(hex8), 32'h4080C0);
        wait_pulse(1'b0, 300, n);
        check("t3_hex_w3", 32'(hex8), 32'h4080C0);

        // Test 4: enable dropped at win_cnt=100 for 50 clk
        repeat (100) @(posedge clk);
        #1;
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (cv8 === 1'b1) cnt++;
        end
        check("t4_no_pulse", 32'(cnt), 32'd0);
        check("t4_hex_hold", 32'(hex8), 32'h4080C0);
        enable = 1'b1;
        wait_pulse(1'b0, 300, n);
        check("t4_relat", 32'(n), 32'd256);
        check("t4_hex", 32'(hex8), 32'h4080C0);

        // enable falls exactly on the window-close cycle: no update, no pulse
        duty[0] = 9'd0;
        duty[1] = 9'd0;
        duty[2] = 9'd0;
        repeat (255) @(posedge clk);
        #1;
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (cv8 === 1'b1) cnt++;
        end
        check("close_no_pulse", 32'(cnt), 32'd0);
        check("close_hex_hold", 32'(hex8), 32'h4080C0);

        // Test 2: constant high then constant low
        duty[0] = 9'd256;
        duty[1] = 9'd256;
        duty[2] = 9'd256;
        enable = 1'b1;
        repeat (3) wait_pulse(1'b0, 300, n);
        check("t2_hex_high", 32'(hex8), 32'hFFFFFF);
        check("t2_act_high", 32'(act8), 32'h0);
        duty[0] = 9'd0;
        duty[1] = 9'd0;
        duty[2] = 9'd0;
        repeat (3) wait_pulse(1'b0, 300, n);
        check("t2_hex_low", 32'(hex8), 32'h000000);
        check("t2_act_low", 32'(act8), 32'h0);

        // Test 5: reset mid-window, then recovery
        duty[0] = 9'd64;
        duty[1] = 9'd128;
        duty[2] = 9'd192;
        repeat (2) wait_pulse(1'b0, 300, n);
        check("t5_pre_hex", 32'(hex8), 32'h4080C0);
        repeat (100) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_rst_hex", 32'(hex8), 32'h0);
        check("t5_rst_valid", 32'(cv8), 32'h0);
        check("t5_rst_active", 32'(act8), 32'h0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b1;
        wait_pulse(1'b0, 300, n);
        check("t5_lat", 32'(n), 32'd256);
        check("t5_hex", 32'(hex8), 32'h4080C0);
        check("t5_active", 32'(act8), 32'h7);

        // Test 6: WIDTH=4, R 4/16, G 12/16, B low with one 1-clk spike
`ifdef RGB_PWM_DEGLITCH_EN
        exp4     = 24'h40C000;
        exp_act4 = 3'b011;
`else
        exp4     = 24'h40C010;
        exp_act4 = 3'b111;
`endif
        enable4 = 1'b1;
        wait_pulse(1'b1, 40, n);
        check("t6_first_lat", 32'(n), 32'd16);
        t = cyc;
        wait_pulse(1'b1, 40, n);
        check("t6_spacing", 32'(cyc - t), 32'd16);
        check("t6_hex", 32'(hex4), 32'(exp4));
        check("t6_active", 32'(act4), 32'(exp_act4));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
